// File: rtl/ultrasonic_ranger_mc.sv
// Multi-channel HC-SR04 ranger: round-robin trigger, echo timing in whole cm, timeout flag.
// Define ULTRA_SEG_EN to add a two-digit seven-segment readout of channel 0.
module ultrasonic_ranger_mc #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int N_CH     = 4,
    parameter int TRIG_CYC = CLK_HZ / 100_000,
    parameter int CM_CYC   = (CLK_HZ / 1_000_000) * 58,
    parameter int MAX_CM   = 400,
    parameter int GAP_CYC  = (CLK_HZ / 1000) * 60,
    localparam int DW      = $clog2(MAX_CM + 1),
    localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_CH-1:0] echo,
    output logic [N_CH-1:0] trig,
    output logic [DW-1:0]   dist_cm,
    output logic [CW-1:0]   dist_ch,
    output logic            dist_valid,
    output logic            timeout,
`ifdef ULTRA_SEG_EN
    output logic [6:0]      seg_ones,
    output logic [6:0]      seg_tens,
`endif
    output logic            busy
);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

    localparam logic [31:0] TRIG_LAST  = 32'(TRIG_CYC - 1);
    localparam logic [31:0] RISE_LAST  = 32'((MAX_CM + 1) * CM_CYC - 1);
    localparam logic [31:0] PRESC_LAST = 32'(CM_CYC - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYC - 1);

    state_t          state;
    logic [CW-1:0]   ch;
    logic [31:0]     cnt;
    logic [31:0]     presc;
    logic [DW-1:0]   cm;
    logic [N_CH-1:0] echo_s1, echo_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ch         <= '0;
            cnt        <= '0;
            presc      <= '0;
            cm         <= '0;
            trig       <= '0;
            dist_cm    <= '0;
            dist_ch    <= '0;
            timeout    <= 1'b0;
            dist_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dist_valid <= 1'b0;
            case (state)
                IDLE: if (en) begin
                    state    <= TRIG;
                    trig[ch] <= 1'b1;
                    cnt      <= '0;
                    busy     <= 1'b1;
                end
                TRIG: if (cnt == TRIG_LAST) begin
                    trig  <= '0;
                    cnt   <= '0;
                    state <= WAIT_RISE;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                WAIT_RISE: if (echo_s2[ch]) begin
                    // The entry cycle is already an echo-high cycle, so count it here.
                    state <= MEASURE;
                    if (PRESC_LAST == 32'd0) begin
                        presc <= '0;
                        cm    <= DW'(1);
                    end else begin
                        presc <= 32'd1;
                        cm    <= '0;
                    end
                end else if (cnt == RISE_LAST) begin
                    dist_valid <= 1'b1;
                    dist_ch    <= ch;
                    dist_cm    <= DW'(MAX_CM);
                    timeout    <= 1'b1;
                    cnt        <= '0;
                    state      <= GAP;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                MEASURE: if (!echo_s2[ch]) begin
                    dist_valid <= 1'b1;
                    dist_ch    <= ch;
                    dist_cm    <= cm;
                    timeout    <= 1'b0;
                    cnt        <= '0;
                    state      <= GAP;
                end else if (presc == PRESC_LAST) begin
                    presc <= '0;
                    if (cm == DW'(MAX_CM)) begin
                        dist_valid <= 1'b1;
                        dist_ch    <= ch;
                        dist_cm    <= DW'(MAX_CM);
                        timeout    <= 1'b1;
                        cnt        <= '0;
                        state      <= GAP;
                    end else begin
                        cm <= cm + 1'b1;
                    end
                end else begin
                    presc <= presc + 32'd1;
                end
                GAP: if (cnt == GAP_LAST) begin
                    cnt   <= '0;
                    ch    <= (ch == CW'(N_CH - 1)) ? '0 : ch + 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ULTRA_SEG_EN
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;
            4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;
            4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;
            4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;
            4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0010000;
            default: seg7 = SEG_DASH;
        endcase
    endfunction

    logic       conv;
    logic [6:0] rem;
    logic [3:0] tens;

    // Repeated subtraction of 10; only values below 100 are converted, so at most 9 steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_ones <= 7'h7F;
            seg_tens <= 7'h7F;
            conv     <= 1'b0;
            rem      <= '0;
            tens     <= '0;
        end else if (dist_valid && dist_ch == '0) begin
            if (timeout || 32'(dist_cm) >= 32'd100) begin
                seg_ones <= SEG_DASH;
                seg_tens <= SEG_DASH;
                conv     <= 1'b0;
            end else begin
                rem  <= 7'(dist_cm);
                tens <= '0;
                conv <= 1'b1;
            end
        end else if (conv) begin
            if (rem >= 7'd10) begin
                rem  <= rem - 7'd10;
                tens <= tens + 4'd1;
            end else begin
                seg_ones <= seg7(rem[3:0]);
                seg_tens <= seg7(tens);
                conv     <= 1'b0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Directed bench for ultrasonic_ranger_mc with N_CH=2, TRIG_CYC=5, CM_CYC=10, MAX_CM=20, GAP_CYC=8.
// Seven-segment checks run only when ULTRA_SEG_EN is defined.
module tb_ultrasonic_ranger_mc;
    logic       clk = 1'b0;
    logic       rst, en;
    logic [1:0] echo;
    logic [1:0] trig;
    logic [4:0] dist_cm;
    logic [0:0] dist_ch;
    logic       dist_valid, timeout, busy;
`ifdef ULTRA_SEG_EN
    logic [6:0] seg_ones, seg_tens;
`endif

    int vec = 0;
    int errs = 0;

    ultrasonic_ranger_mc #(
        .N_CH(2), .TRIG_CYC(5), .CM_CYC(10), .MAX_CM(20), .GAP_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .echo(echo), .trig(trig),
        .dist_cm(dist_cm), .dist_ch(dist_ch), .dist_valid(dist_valid),
        .timeout(timeout),
`ifdef ULTRA_SEG_EN
        .seg_ones(seg_ones), .seg_tens(seg_tens),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; echo = 2'b00;
        tick(); tick();
        rst = 1'b0;
        tick();
        vec++; if (trig !== 2'b00) begin errs++; $display("FAIL reset_trig: got %b want 00", trig); end
        vec++; if (dist_cm !== 5'd0) begin errs++; $display("FAIL reset_dist_cm: got %0d want 0", dist_cm); end
        vec++; if (dist_ch !== 1'b0) begin errs++; $display("FAIL reset_dist_ch: got %0d want 0", dist_ch); end
        vec++; if (timeout !== 1'b0) begin errs++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        vec++; if (dist_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", dist_valid); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef ULTRA_SEG_EN
        vec++; if ({seg_tens, seg_ones} !== 14'h3FFF) begin errs++; $display("FAIL reset_seg: got %h want 3fff", {seg_tens, seg_ones}); end
`endif
    endtask

    // Channel 0: 5-cycle trigger, then 57 echo-high cycles -> 5 cm.
    task automatic test_first_ping();
        int  n;
        logic t1, early, d0, d1;
        en = 1'b1;
        tick();
        vec++; if (trig !== 2'b01) begin errs++; $display("FAIL trig_start: got %b want 01", trig); end
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL busy_start: got %b want 1", busy); end
        n = 1; t1 = 1'b0; early = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (trig[0]) n++;
            if (trig[1]) t1 = 1'b1;
        end
        vec++; if (n !== 5) begin errs++; $display("FAIL trig_width: got %0d want 5", n); end
        echo = 2'b01;
        for (int i = 0; i < 57; i++) begin
            tick();
            if (dist_valid) early = 1'b1;
            if (trig[1]) t1 = 1'b1;
        end
        echo = 2'b00;
        tick(); d0 = dist_valid;
        tick(); d1 = dist_valid;
        tick();
        vec++; if ({early, d0, d1, dist_valid} !== 4'b0001) begin errs++; $display("FAIL valid_latency: got %b want 0001", {early, d0, d1, dist_valid}); end
        vec++; if (dist_cm !== 5'd5) begin errs++; $display("FAIL cm57: got %0d want 5", dist_cm); end
        vec++; if (dist_ch !== 1'b0) begin errs++; $display("FAIL ch57: got %0d want 0", dist_ch); end
        vec++; if (timeout !== 1'b0) begin errs++; $display("FAIL to57: got %b want 0", timeout); end
        tick();
        vec++; if ({dist_valid, busy} !== 2'b01) begin errs++; $display("FAIL one_pulse_gap: got %b want 01", {dist_valid, busy}); end
        vec++; if (t1 !== 1'b0) begin errs++; $display("FAIL trig1_idle: got %b want 0", t1); end
    endtask

    // Channel 1 never echoes: GAP of 8, then 5 trig + 210 wait cycles -> timeout.
    task automatic test_ch1_timeout();
        int   n;
        logic t0;
        n = 0;
        while (trig === 2'b00 && n < 50) begin tick(); n++; end
        vec++; if (n !== 8) begin errs++; $display("FAIL gap_len: got %0d want 8", n); end
        vec++; if (trig !== 2'b10) begin errs++; $display("FAIL trig_ch1: got %b want 10", trig); end
        n = 0; t0 = 1'b0;
        do begin tick(); n++; if (trig[0]) t0 = 1'b1; end while (dist_valid !== 1'b1 && n < 400);
        vec++; if (n !== 215) begin errs++; $display("FAIL rise_timeout_time: got %0d want 215", n); end
        vec++; if ({dist_ch, dist_cm, timeout} !== {1'b1, 5'd20, 1'b1}) begin errs++; $display("FAIL rise_timeout: got ch %0d cm %0d to %b want ch 1 cm 20 to 1", dist_ch, dist_cm, timeout); end
        vec++; if (t0 !== 1'b0) begin errs++; $display("FAIL trig0_during_ch1: got %b want 0", t0); end
    endtask

    // Back on channel 0, echo held far too long -> saturates after 210 high cycles.
    task automatic test_ch0_long();
        int n;
        n = 0;
        while (trig === 2'b00 && n < 50) begin tick(); n++; end
        vec++; if ({n, trig} !== {32'd9, 2'b01}) begin errs++; $display("FAIL rr_return: got n %0d trig %b want n 9 trig 01", n, trig); end
        repeat (5) tick();
        echo = 2'b01;
        n = 0;
        do begin tick(); n++; end while (dist_valid !== 1'b1 && n < 400);
        vec++; if (n !== 212) begin errs++; $display("FAIL meas_timeout_time: got %0d want 212", n); end
        vec++; if ({dist_ch, dist_cm, timeout} !== {1'b0, 5'd20, 1'b1}) begin errs++; $display("FAIL meas_timeout: got ch %0d cm %0d to %b want ch 0 cm 20 to 1", dist_ch, dist_cm, timeout); end
    endtask

    // Channel 1 echoes 30 cycles while channel 0 echo stays high and must be ignored.
    task automatic test_ch1_short();
        int n;
        n = 0;
        while (trig === 2'b00 && n < 50) begin tick(); n++; end
        vec++; if ({n, trig} !== {32'd9, 2'b10}) begin errs++; $display("FAIL trig_ch1b: got n %0d trig %b want n 9 trig 10", n, trig); end
        repeat (5) tick();
        echo = 2'b11;
        repeat (30) tick();
        echo = 2'b01;
        tick(); tick(); tick();
        vec++; if ({dist_valid, dist_ch, dist_cm, timeout} !== {1'b1, 1'b1, 5'd3, 1'b0}) begin errs++; $display("FAIL ch1_30: got v %b ch %0d cm %0d to %b want v 1 ch 1 cm 3 to 0", dist_valid, dist_ch, dist_cm, timeout); end
        echo = 2'b00;
    endtask

    // en dropped mid-measure: result and GAP complete, then IDLE with no more triggers.
    task automatic test_en_drop();
        int   n;
        logic bad;
        n = 0;
        while (trig === 2'b00 && n < 50) begin tick(); n++; end
        vec++; if (trig !== 2'b01) begin errs++; $display("FAIL trig_drop: got %b want 01", trig); end
        repeat (5) tick();
        echo = 2'b01;
        repeat (20) tick();
        en = 1'b0;
        repeat (15) tick();
        echo = 2'b00;
        tick(); tick(); tick();
        vec++; if ({dist_valid, dist_ch, dist_cm} !== {1'b1, 1'b0, 5'd3}) begin errs++; $display("FAIL drop_result: got v %b ch %0d cm %0d want v 1 ch 0 cm 3", dist_valid, dist_ch, dist_cm); end
        repeat (7) tick();
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL drop_gap_busy: got %b want 1", busy); end
        tick();
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL drop_idle: got %b want 0", busy); end
        bad = 1'b0;
        repeat (20) begin tick(); if (trig !== 2'b00 || busy !== 1'b0) bad = 1'b1; end
        vec++; if (bad !== 1'b0) begin errs++; $display("FAIL drop_stays_idle: got %b want 0", bad); end
    endtask

    // Re-enable pings channel 1 (ch preserved); reset during TRIG then restarts on channel 0.
    task automatic test_rst_mid_trig();
        en = 1'b1;
        tick();
        vec++; if (trig !== 2'b10) begin errs++; $display("FAIL ch_preserved: got %b want 10", trig); end
        tick(); tick();
        rst = 1'b1; en = 1'b0;
        tick();
        vec++; if ({trig, dist_valid, busy} !== 4'b0000) begin errs++; $display("FAIL rst_mid: got %b want 0000", {trig, dist_valid, busy}); end
        rst = 1'b0;
        tick(); tick();
        vec++; if ({trig, dist_valid} !== 3'b000) begin errs++; $display("FAIL rst_quiet: got %b want 000", {trig, dist_valid}); end
        en = 1'b1;
        tick();
        vec++; if (trig !== 2'b01) begin errs++; $display("FAIL rst_ch0: got %b want 01", trig); end
    endtask

`ifdef ULTRA_SEG_EN
    task automatic test_seg();
        int n;
        repeat (5) tick();
        echo = 2'b01;
        repeat (175) tick();
        echo = 2'b00;
        tick(); tick(); tick();
        vec++; if ({dist_valid, dist_cm} !== {1'b1, 5'd17}) begin errs++; $display("FAIL seg_src: got v %b cm %0d want v 1 cm 17", dist_valid, dist_cm); end
        repeat (12) tick();
        vec++; if (seg_tens !== 7'b1111001) begin errs++; $display("FAIL seg_tens17: got %b want 1111001", seg_tens); end
        vec++; if (seg_ones !== 7'b1111000) begin errs++; $display("FAIL seg_ones17: got %b want 1111000", seg_ones); end
        for (int p = 0; p < 2; p++) begin
            n = 0;
            do begin tick(); n++; end while (dist_valid !== 1'b1 && n < 400);
        end
        vec++; if ({dist_ch, timeout} !== 2'b01) begin errs++; $display("FAIL seg_to_src: got ch %0d to %b want ch 0 to 1", dist_ch, timeout); end
        repeat (12) tick();
        vec++; if ({seg_tens, seg_ones} !== {7'b0111111, 7'b0111111}) begin errs++; $display("FAIL seg_dash: got %b %b want 0111111 0111111", seg_tens, seg_ones); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_ping();
        test_ch1_timeout();
        test_ch0_long();
        test_ch1_short();
        test_en_drop();
        test_rst_mid_trig();
`ifdef ULTRA_SEG_EN
        test_seg();
`endif
        en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/ultrasonic_ranger_mc.md
# ultrasonic_ranger_mc

Multi-channel, parametrised HC-SR04-style ultrasonic ranger. One trigger/echo pair per sensor channel; channels are pinged round-robin so their bursts never overlap. Each ping returns a distance in whole centimetres with a one-cycle valid strobe, channel tag and timeout flag. Sits between the sensor header pins and the distance consumers, with an optional two-digit seven-segment readout for board bring-up.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency. Documentation only; derive the other defaults from it.
- `N_CH`, 4: number of sensor channels, 1..8.
- `TRIG_CYC`, 500: trigger pulse width in clocks (10 µs).
- `CM_CYC`, 2900: clocks per centimetre of round-trip echo (58 µs).
- `MAX_CM`, 400: maximum reported distance.
- `GAP_CYC`, 3_000_000: dead time after each ping before the next channel is pinged (60 ms).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  ranging enable.
- `echo`  in  N_CH  raw echo inputs, asynchronous.
- `trig`  out  N_CH  trigger outputs, active-high.
- `dist_cm`  out  clog2(MAX_CM+1)  last measured distance.
- `dist_ch`  out  max(1,clog2(N_CH))  channel of `dist_cm`.
- `dist_valid`  out  1  one-cycle strobe: `dist_cm`, `dist_ch` and `timeout` are new.
- `timeout`  out  1  the last result was a timeout.
- `busy`  out  1  the FSM is not in IDLE.
- `seg_ones`, `seg_tens`  out  7 each  active-low segments {g,f,e,d,c,b,a}. Present only with `ULTRA_SEG_EN`.

## Operation
- Each `echo` bit passes through a 2-flop synchroniser. The FSM sees only the synchronised value.
- FSM states:
  - IDLE → TRIG when `en`=1.
  - TRIG: `trig[ch]` is high for exactly `TRIG_CYC` cycles → WAIT_RISE.
  - WAIT_RISE: waits for synchronised `echo[ch]`=1 → MEASURE.
    - If no rise arrives within (MAX_CM+1)·CM_CYC cycles: timeout result → GAP.
  - MEASURE: a prescaler counts 0..CM_CYC-1; on each wrap, the cm counter increments.
    - On synchronised `echo[ch]`=0: result is the cm counter (truncated, no rounding) → GAP.
    - If the cm counter reaches MAX_CM+1: timeout result → GAP.
  - GAP: counts `GAP_CYC` cycles, then `ch` ← (ch==N_CH-1) ? 0 : ch+1 → IDLE.
- Result cycle:
  - `dist_valid`=1 and `dist_ch`=ch.
  - Normal result: `timeout`=0 and `dist_cm`=count.
  - Timeout: `timeout`=1 and `dist_cm`=MAX_CM.
  - `dist_cm`, `dist_ch` and `timeout` hold until the next result.
- Only `trig[ch]` may be high; every other `trig` bit is always 0.
- Echo on a non-selected channel is ignored.
- `en` dropped mid-ping: the current ping completes, including its result and GAP. The FSM then stays in IDLE with `ch` preserved.
- `en` high in IDLE: TRIG is entered on the next edge.
- An echo already high on entry to WAIT_RISE counts as a rise; it is not re-armed.

## Timing
- Reset values:
  - `trig`=0, `dist_cm`=0, `dist_ch`=0, `timeout`=0, `dist_valid`=0, `busy`=0.
  - FSM in IDLE, `ch`=0, all counters 0.
  - `seg_ones`=`seg_tens`=7'h7F (blank).
- `rst` mid-ping: `trig` is 0 after the reset edge and no result is emitted.
- `trig[ch]` rises on the first edge after IDLE samples `en`=1.
- Echo latency: a raw echo edge that settles before edge k is seen by the FSM at edge k+2.
  - After a raw falling edge, `dist_valid` is registered at edge k+2.
- Echo high for H cycles (synchronised) → `dist_cm` = floor(H / CM_CYC), saturating at the timeout rule.
- `busy` is registered with the FSM state.

## Configuration
- `ULTRA_SEG_EN` defined:
  - On each `dist_valid` with `dist_ch`=0, the value is latched and converted to BCD by a sequential converter.
  - `seg_ones`/`seg_tens` update no later than 12 cycles after `dist_valid` and show cm mod 10 and tens digit.
  - Values ≥100 and timeouts show "--" (7'b0111111 on both).
  - A new result arriving during conversion restarts the conversion.
- `ULTRA_SEG_EN` undefined: the seven-segment ports, converter and related logic are absent. All other behaviour is identical.

## Test plan
Bench parameters: N_CH=2, TRIG_CYC=5, CM_CYC=10, MAX_CM=20, GAP_CYC=8.
- Reset, then `en`=1:
  - `trig[0]` is high for exactly 5 cycles.
  - `trig[1]`=0 throughout.
  - `busy`=1 from the cycle after `en` is sampled.
- Channel 0 echo held high for 57 cycles after the trigger → one `dist_valid` pulse with `dist_cm`=5, `dist_ch`=0, `timeout`=0, arriving 2 edges after the echo falls.
- Channel 0 echo held high for 250 cycles → `dist_valid` after 210 synchronised high cycles, with `dist_cm`=20 and `timeout`=1.
- Channel 1 echo never rises → timeout result with `dist_ch`=1 and `dist_cm`=20. Round-robin then returns to channel 0 after GAP.
- Drop `en` during MEASURE of channel 0 → the result still arrives, GAP runs, the FSM stays in IDLE, `busy`=0, and no further `trig`.
- Assert `rst` during TRIG → `trig`=0 and `dist_valid`=0 after the edge; the next `en` pings channel 0.
- With `ULTRA_SEG_EN`:
  - Channel 0 result of 17 cm → `seg_tens`=7'b1111001 ("1") and `seg_ones`=7'b1111000 ("7") within 12 cycles.
  - A timeout result → "--" on both digits.
